// File: rtl/atan_share_ctrl_if.sv
// Request, response and core-side signal bundle of the shared arctangent controller.
// "slave" is the controller's view; "master" is the requester/downstream/core environment.
interface atan_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*17-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [11:0]        rsp_data;
  logic               rsp_err;
  logic               busy;
  logic               core_trig;
  logic [16:0]        core_para;
  logic               core_vld;
  logic [11:0]        core_atany;

  modport slave (
    input  req_valid, req_data, rsp_ready, core_vld, core_atany,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy, core_trig, core_para
  );

  modport master (
    output req_valid, req_data, rsp_ready, core_vld, core_atany,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy, core_trig, core_para
  );
endinterface

// File: rtl/atan_share_ctrl.sv
// Round-robin time-sharing of one iterative arctangent core among NREQ requesters,
// with a watchdog on the core's done pulse and an id-tagged valid/ready response.
module atan_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15,
  parameter int TMR_W   = 5
) (
  input logic               clk,
  input logic               rst,
  atan_share_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e             state_r;
  state_e             state_n;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ID_W-1:0]    id_r;
  logic [16:0]        core_para_r;
  logic [TMR_W-1:0]   tmr_r;
  logic [11:0]        rsp_data_r;
  logic               rsp_err_r;
  logic               rsp_valid_r;
  logic               core_trig_r;
  logic               busy_r;

  logic [ID_W:0]      pick_s;
  logic [ID_W-1:0]    grant_s;
  logic               grant_hit_s;
  logic [NREQ-1:0]    req_ready_s;
  logic [NREQ*17-1:0] data_sh_s;
  logic [16:0]        op_sel_s;
  logic [TMR_W-1:0]   tmr_inc_s;
  logic               timeout_s;
  logic [ID_W-1:0]    rr_next_s;

  // First set request at or above ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [ID_W-1:0] ptr);
    logic [ID_W:0]   res;
    logic [NREQ-1:0] sh;
    int unsigned     idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (32'(ptr) + 32'(k)) % 32'(NREQ);
      sh  = valid >> idx;
      if (sh[0]) begin
        res = {1'b1, idx[ID_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Grant selection, operand mux and watchdog arithmetic.
  always_comb begin
    pick_s      = rr_pick(bus.req_valid, rr_ptr_r);
    grant_s     = pick_s[ID_W-1:0];
    grant_hit_s = pick_s[ID_W];
    data_sh_s   = bus.req_data >> (17 * int'(grant_s));
    op_sel_s    = data_sh_s[16:0];
    tmr_inc_s   = tmr_r + TMR_W'(1'b1);
    // tmr_inc_s is the number of WAIT cycles elapsed including this one
    timeout_s   = (tmr_inc_s == TMR_W'(TIMEOUT - 1));
    if (id_r == ID_W'(NREQ - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = id_r + ID_W'(1'b1);
    end
  end

  // Next-state decode; req_ready is the only combinational output.
  always_comb begin
    state_n     = state_r;
    req_ready_s = '0;
    case (state_r)
      IDLE: begin
        if (grant_hit_s) begin
          state_n     = ISSUE;
          req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_s;
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (bus.core_vld || timeout_s) begin
          state_n = RESP;
        end else begin
          state_n = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, round-robin pointer, operand/result registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      id_r        <= '0;
      core_para_r <= 17'd0;
      tmr_r       <= '0;
      rsp_data_r  <= 12'd0;
      rsp_err_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      core_trig_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      rsp_valid_r <= (state_n == RESP);
      core_trig_r <= (state_n == ISSUE);
      busy_r      <= (state_n != IDLE);
      case (state_r)
        IDLE: begin
          if (grant_hit_s) begin
            id_r        <= grant_s;
            core_para_r <= op_sel_s;
          end
        end
        ISSUE: begin
          tmr_r <= '0;
        end
        WAIT: begin
          tmr_r <= tmr_inc_s;
          // a done pulse coinciding with expiry still delivers the real result
          if (bus.core_vld) begin
            rsp_data_r <= bus.core_atany;
            rsp_err_r  <= 1'b0;
          end else if (timeout_s) begin
            rsp_data_r <= 12'd0;
            rsp_err_r  <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rr_ptr_r <= rr_next_s;
          end
        end
        default: begin
          tmr_r <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = id_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.busy      = busy_r;
  assign bus.core_trig = core_trig_r;
  assign bus.core_para = core_para_r;

endmodule

// File: tb/tb_atan_share_ctrl.sv
// Bench for atan_share_ctrl: core stub with fixed-latency done pulse, round-robin and
// latency reference model, randomized operands/masks.
module tb_atan_share_ctrl;
  localparam int NREQ     = 4;
  localparam int ID_W     = 2;
  localparam int TIMEOUT  = 15;
  localparam int TMR_W    = 5;
  localparam int CORE_LAT = 11;
  localparam int RSP_LAT  = CORE_LAT + 2;   // accept cycle -> rsp_valid cycle
  localparam int TO_LAT   = TIMEOUT + 1;    // accept cycle -> rsp_valid on watchdog

  logic clk;
  logic rst;

  atan_share_ctrl_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  atan_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          rr_m        = 0;
  logic [16:0] op_m [NREQ];
  int          stub_mode   = 0;      // 0 fixed value, 1 silent, 2 arctangent model
  logic [11:0] stub_val    = 12'd0;
  int          due         = -1;
  logic [11:0] due_val     = 12'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] atan_ref(input logic [16:0] op);
    real r;
    r = $atan($itor($signed(op)) / 256.0) * 1024.0;
    if (r >= 0.0) r = r + 0.5;
    else r = r - 0.5;
    return 12'($rtoi(r));
  endfunction

  // Core stub: done pulse CORE_LAT cycles after the trigger cycle, noise otherwise.
  always @(negedge clk) begin
    if (bus.core_trig === 1'b1 && stub_mode != 1) begin
      due     = cyc + CORE_LAT;
      due_val = (stub_mode == 2) ? atan_ref(bus.core_para) : stub_val;
    end
    bus.core_vld   = (cyc == due);
    bus.core_atany = (cyc == due) ? due_val : 12'(cyc * 37);
  end

  function automatic int pick_m(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic apply_ops();
    for (int i = 0; i < NREQ; i++) bus.req_data[17*i +: 17] = op_m[i];
  endtask

  task automatic drain();
    int ok;
    ok = 0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 4 * TO_LAT && ok == 0; t++) begin
      #1;
      if (bus.busy === 1'b0) ok = 1;
      else @(negedge clk);
    end
    vectors++;
    if (ok == 0) begin
      miscompares++;
      $display("FAIL drain: busy=%b still set, want 0 within %0d cycles", bus.busy, 4 * TO_LAT);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    #1;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.busy, bus.core_trig} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: valid/err/busy/trig=%b want 0000",
               {bus.rsp_valid, bus.rsp_err, bus.busy, bus.core_trig});
    end
    vectors++;
    if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 12'd0 || bus.core_para !== 17'd0 || bus.req_ready !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_data: id=%0d data=%0h para=%0h ready=%b want all 0",
               bus.rsp_id, bus.rsp_data, bus.core_para, bus.req_ready);
    end
  endtask

  task automatic test_single();
    int g;
    stub_mode = 0;
    stub_val  = 12'd123;
    bus.rsp_ready = 1'b1;
    op_m[2] = 17'sd100;
    apply_ops();
    g = pick_m(4'b0100, rr_m);
    bus.req_valid = 4'b0100;
    #1;
    vectors++;
    if (bus.req_ready !== onehot(g)) begin
      miscompares++;
      $display("FAIL single_accept: req_ready=%b want %b", bus.req_ready, onehot(g));
    end
    @(negedge clk);
    bus.req_valid = '0;
    for (int k = 1; k <= RSP_LAT + 1; k++) begin
      #1;
      vectors++;
      if (bus.core_trig !== (k == 1) || bus.rsp_valid !== (k == RSP_LAT) || bus.busy !== (k <= RSP_LAT)) begin
        miscompares++;
        $display("FAIL single_timing A+%0d: trig=%b valid=%b busy=%b want %b %b %b", k,
                 bus.core_trig, bus.rsp_valid, bus.busy, k == 1, k == RSP_LAT, k <= RSP_LAT);
      end
      if (k == 1) begin
        vectors++;
        if (bus.core_para !== 17'd100) begin
          miscompares++;
          $display("FAIL single_para: core_para=%0d want 100", bus.core_para);
        end
      end
      if (k == RSP_LAT) begin
        vectors++;
        if (bus.rsp_id !== 2'd2 || bus.rsp_data !== 12'd123 || bus.rsp_err !== 1'b0) begin
          miscompares++;
          $display("FAIL single_rsp: id=%0d data=%0d err=%b want 2 123 0",
                   bus.rsp_id, bus.rsp_data, bus.rsp_err);
        end
      end
      @(negedge clk);
    end
    rr_m = (g + 1) % NREQ;
  endtask

  task automatic test_round_robin();
    int ngr, last, cur, g, eg;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    stub_mode = 0;
    stub_val  = 12'($urandom);
    for (int i = 0; i < NREQ; i++) op_m[i] = 17'($urandom);
    apply_ops();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    ngr  = 0;
    last = -1;
    cur  = -1;
    for (int t = 0; t < 6 * (RSP_LAT + 1) && ngr < 5; t++) begin
      #1;
      vectors++;
      if ($countones(bus.req_ready) > 1) begin
        miscompares++;
        $display("FAIL rr_onehot: req_ready=%b has more than one bit", bus.req_ready);
      end
      if (bus.rsp_valid === 1'b1) begin
        vectors++;
        if (int'(bus.rsp_id) != cur || bus.rsp_data !== stub_val || bus.rsp_err !== 1'b0) begin
          miscompares++;
          $display("FAIL rr_rsp: id=%0d data=%0h err=%b want %0d %0h 0",
                   bus.rsp_id, bus.rsp_data, bus.rsp_err, cur, stub_val);
        end
      end
      if (bus.req_ready !== 4'd0) begin
        g = -1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
        eg = pick_m(4'hF, rr_m);
        vectors++;
        if (g != eg) begin
          miscompares++;
          $display("FAIL rr_order grant %0d: got req %0d want req %0d", ngr, g, eg);
        end
        if (last >= 0) begin
          vectors++;
          if (t - last != RSP_LAT + 1) begin
            miscompares++;
            $display("FAIL rr_gap: %0d cycles between grants, want %0d", t - last, RSP_LAT + 1);
          end
        end
        last = t;
        cur  = g;
        rr_m = (g + 1) % NREQ;
        ngr++;
      end
      @(negedge clk);
    end
    vectors++;
    if (ngr != 5) begin
      miscompares++;
      $display("FAIL rr_count: %0d grants seen, want 5", ngr);
    end
    drain();
  endtask

  task automatic test_timeout();
    int r, g;
    stub_mode = 1;
    bus.rsp_ready = 1'b1;
    r = $urandom_range(0, NREQ - 1);
    op_m[r] = 17'($urandom);
    apply_ops();
    g = pick_m(onehot(r), rr_m);
    bus.req_valid = onehot(r);
    #1;
    vectors++;
    if (bus.req_ready !== onehot(g)) begin
      miscompares++;
      $display("FAIL to_accept: req_ready=%b want %b", bus.req_ready, onehot(g));
    end
    @(negedge clk);
    bus.req_valid = '0;
    for (int k = 1; k <= TO_LAT + 1; k++) begin
      #1;
      vectors++;
      if (bus.core_trig !== (k == 1) || bus.rsp_valid !== (k == TO_LAT)) begin
        miscompares++;
        $display("FAIL to_timing A+%0d: trig=%b valid=%b want %b %b", k,
                 bus.core_trig, bus.rsp_valid, k == 1, k == TO_LAT);
      end
      if (k == TO_LAT) begin
        vectors++;
        if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 12'd0 || int'(bus.rsp_id) != g) begin
          miscompares++;
          $display("FAIL to_rsp: err=%b data=%0h id=%0d want 1 0 %0d",
                   bus.rsp_err, bus.rsp_data, bus.rsp_id, g);
        end
      end
      @(negedge clk);
    end
    rr_m = (g + 1) % NREQ;
    // a normal transaction right after the watchdog
    stub_mode = 0;
    stub_val  = 12'($urandom);
    r = $urandom_range(0, NREQ - 1);
    g = pick_m(onehot(r), rr_m);
    bus.req_valid = onehot(r);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (RSP_LAT - 1) @(negedge clk);
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_data !== stub_val || int'(bus.rsp_id) != g) begin
      miscompares++;
      $display("FAIL to_recover: valid=%b err=%b data=%0h id=%0d want 1 0 %0h %0d",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_id, stub_val, g);
    end
    rr_m = (g + 1) % NREQ;
    drain();
  endtask

  task automatic test_backpressure();
    int r, g, eg;
    logic [NREQ-1:0] mask;
    stub_mode = 0;
    stub_val  = 12'($urandom);
    bus.rsp_ready = 1'b0;
    r = $urandom_range(0, NREQ - 1);
    g = pick_m(onehot(r), rr_m);
    bus.req_valid = onehot(r);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (RSP_LAT - 1) @(negedge clk);
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != g || bus.rsp_data !== stub_val || bus.rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_first: valid=%b id=%0d data=%0h err=%b want 1 %0d %0h 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, g, stub_val);
    end
    mask = 4'($urandom_range(1, 15));
    for (int i = 0; i < NREQ; i++) op_m[i] = 17'($urandom);
    apply_ops();
    bus.req_valid = mask;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != g || bus.rsp_data !== stub_val ||
          bus.rsp_err !== 1'b0 || bus.req_ready !== 4'd0 || bus.core_trig !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold %0d: valid=%b id=%0d data=%0h err=%b ready=%b trig=%b", j,
                 bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req_ready, bus.core_trig);
      end
    end
    bus.rsp_ready = 1'b1;
    rr_m = (g + 1) % NREQ;
    eg = pick_m(mask, rr_m);
    @(negedge clk);
    #1;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== onehot(eg)) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b ready=%b want 0 %b", bus.rsp_valid, bus.req_ready, onehot(eg));
    end
    @(negedge clk);
    rr_m = (eg + 1) % NREQ;
    drain();
  endtask

  task automatic test_reset_mid();
    int r, eg;
    stub_mode = 0;
    stub_val  = 12'($urandom);
    bus.rsp_ready = 1'b1;
    r = $urandom_range(0, NREQ - 1);
    op_m[r] = 17'($urandom_range(1, 65535));
    apply_ops();
    bus.req_valid = onehot(r);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    vectors++;
    if (bus.core_trig !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_trig: core_trig=%b want 1", bus.core_trig);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    #1;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_err, bus.busy, bus.core_trig} !== 4'b0000 || bus.rsp_id !== 2'd0 ||
        bus.rsp_data !== 12'd0 || bus.core_para !== 17'd0 || bus.req_ready !== 4'd0) begin
      miscompares++;
      $display("FAIL rm_zero: valid=%b err=%b busy=%b trig=%b id=%0d data=%0h para=%0h ready=%b want all 0",
               bus.rsp_valid, bus.rsp_err, bus.busy, bus.core_trig, bus.rsp_id, bus.rsp_data,
               bus.core_para, bus.req_ready);
    end
    for (int k = 7; k <= 20; k++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rm_quiet A+%0d: valid=%b busy=%b want 0 0", k, bus.rsp_valid, bus.busy);
      end
    end
    eg = pick_m(4'b1001, rr_m);
    bus.req_valid = 4'b1001;
    #1;
    vectors++;
    if (bus.req_ready !== onehot(eg)) begin
      miscompares++;
      $display("FAIL rm_regrant: req_ready=%b want %b", bus.req_ready, onehot(eg));
    end
    @(negedge clk);
    rr_m = (eg + 1) % NREQ;
    drain();
  endtask

  task automatic test_random();
    int g;
    logic [NREQ-1:0] mask;
    stub_mode = 0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) op_m[i] = 17'($urandom);
      apply_ops();
      stub_val = 12'($urandom);
      g = pick_m(mask, rr_m);
      bus.req_valid = mask;
      #1;
      vectors++;
      if (bus.req_ready !== onehot(g)) begin
        miscompares++;
        $display("FAIL rnd_grant %0d: req_ready=%b want %b mask=%b", n, bus.req_ready, onehot(g), mask);
      end
      @(negedge clk);
      bus.req_valid = '0;
      for (int k = 1; k <= RSP_LAT; k++) begin
        #1;
        vectors++;
        if (bus.core_trig !== (k == 1) || bus.rsp_valid !== (k == RSP_LAT) ||
            (k == 1 && bus.core_para !== op_m[g]) ||
            (k == RSP_LAT && (int'(bus.rsp_id) != g || bus.rsp_data !== stub_val || bus.rsp_err !== 1'b0))) begin
          miscompares++;
          $display("FAIL rnd_txn %0d A+%0d: trig=%b valid=%b para=%0h id=%0d data=%0h err=%b want para %0h id %0d data %0h",
                   n, k, bus.core_trig, bus.rsp_valid, bus.core_para, bus.rsp_id, bus.rsp_data,
                   bus.rsp_err, op_m[g], g, stub_val);
        end
        @(negedge clk);
      end
      rr_m = (g + 1) % NREQ;
    end
  endtask

  task automatic test_real_core();
    logic [16:0] ops_l [5];
    int          exp_l [5];
    int          r, g, d;
    stub_mode = 2;
    bus.rsp_ready = 1'b1;
    ops_l[0] = 17'd0;   exp_l[0] = 0;
    ops_l[1] = 17'd256; exp_l[1] = 804;
    for (int i = 2; i < 5; i++) begin
      ops_l[i] = 17'($urandom);
      exp_l[i] = int'($signed(atan_ref(ops_l[i])));
    end
    for (int i = 0; i < 5; i++) begin
      r = $urandom_range(0, NREQ - 1);
      op_m[r] = ops_l[i];
      apply_ops();
      g = pick_m(onehot(r), rr_m);
      bus.req_valid = onehot(r);
      @(negedge clk);
      bus.req_valid = '0;
      repeat (RSP_LAT - 1) @(negedge clk);
      #1;
      d = int'($signed(bus.rsp_data)) - exp_l[i];
      vectors++;
      if (bus.rsp_valid !== 1'b1 || d > 2 || d < -2 || int'(bus.rsp_id) != g) begin
        miscompares++;
        $display("FAIL real_core op=%0d: valid=%b id=%0d data=%0d want 1 %0d %0d+-2",
                 $signed(ops_l[i]), bus.rsp_valid, bus.rsp_id, $signed(bus.rsp_data), g, exp_l[i]);
      end
      @(negedge clk);
      rr_m = (g + 1) % NREQ;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) op_m[i] = 17'd0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_real_core();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/atan_share_ctrl.md
Name: atan_share_ctrl

Overview:
- Time-shares one iterative arctangent core among NREQ requesters.
- The core is the 17-bit signed input, 12-bit output unit with a one-cycle `trig` start and a one-cycle `vld` done pulse.
- The block accepts requests round-robin, launches the core, waits for `vld` (with a watchdog), and returns the result tagged with the requester id on a single valid/ready response channel.
- It sits between the per-channel angle-estimation front ends and the shared core instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester id; must satisfy 2^ID_W >= NREQ.
- TIMEOUT, 15, cycles to wait in WAIT for `core_vld` before flagging an error; must be >= 12.
- TMR_W, 5, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*17  per-requester signed operand; requester i occupies bits [17*i+16:17*i].
- req_ready  out  NREQ  per-requester accept strobe; at most one bit high.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  downstream accepts result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  12  signed atan result in core scale (1024 = 1 rad).
- rsp_err  out  1  watchdog expired; rsp_data is 0.
- busy  out  1  high in any state other than IDLE.
- core_trig  out  1  start pulse to the core.
- core_para  out  17  operand to the core.
- core_vld  in  1  core done pulse.
- core_atany  in  12  core result, sampled when core_vld = 1.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - State goes to IDLE; rr_ptr = 0.
  - Outputs: req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, core_trig = 0, core_para = 0, busy = 0.
  - Reset mid-operation abandons the transaction with no response. A core_vld that arrives later is ignored, because core_vld is only honoured in WAIT.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant g = the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[g] = 1 combinationally in that same cycle.
  - Latch op = req_data slice g and id = g; go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE:
  - core_trig = 1 for exactly this one cycle.
  - core_para = op (held from ISSUE through WAIT).
  - Clear tmr; go to WAIT.
- WAIT:
  - tmr increments each cycle.
  - If core_vld: capture core_atany into rsp_data, rsp_err = 0, go to RESP.
  - Else if tmr == TIMEOUT-1: rsp_data = 0, rsp_err = 1, go to RESP.
  - core_vld wins if both conditions occur in the same cycle.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid goes to 0 next cycle, rr_ptr = (id + 1) mod NREQ, go to IDLE.
  - No new request is accepted while in RESP.
- core_trig is never asserted outside ISSUE. A core_vld outside WAIT is ignored.
- Latency with the nominal core (vld 11 cycles after trig):
  - accept at cycle A;
  - trig at A+1;
  - core_vld at A+12;
  - rsp_valid at A+13.
  - Minimum turnaround with rsp_ready held at 1: one request per 14 cycles.
- Fairness: a requester that holds req_valid high waits at most NREQ-1 other transactions.
- Requesters must keep req_data stable while req_valid = 1 and req_ready = 0.

Test Plan:
- Stub core with 11-cycle vld, returning 12'd123; single request on req 2, op = 17'sd100, rsp_ready = 1:
  - req_ready[2] high at A;
  - core_trig at A+1 with core_para = 100;
  - rsp_valid at A+13 with rsp_id = 2, rsp_data = 123, rsp_err = 0;
  - busy low at A+14.
- All four req_valid held high, rsp_ready = 1: grant order 0,1,2,3,0; each grant 14 cycles apart; at most one req_ready bit high in any cycle.
- Stub never returns vld: rsp_valid appears 15 cycles after the trig cycle with rsp_err = 1 and rsp_data = 0; a next request afterwards completes normally.
- Backpressure: rsp_ready = 0 for 20 cycles in RESP; rsp_id/rsp_data/rsp_err stay stable, no req_ready is asserted, no core_trig; on release the transaction completes and the next request is accepted.
- rst pulsed 5 cycles after core_trig: all outputs zero next cycle; the stub's vld at trig+11 produces no response; rr_ptr = 0, so the next simultaneous req0 + req3 grants req0.
- Real core integrated:
  - op = 0 gives rsp_data within ±2 of 0.
  - op = 17'sd256 (tan = 1.0 in the core's input scale) gives rsp_data within ±2 of 804.
